// File: rtl/maq_mh.sv
// maq_mh -- minutes/hours time-keeping machine.
//
// Receives the minute carry from the seconds machine, detects its rising
// edge and advances BCD minutes (00-59) and hours (00-23, or 12,01..11 with
// an AM/PM flag when H12_MODE=1). An end-of-day carry pulse is produced on
// the 23:59 -> 00:00 (11:59 PM -> 12:00 AM) rollover. A set mode freezes
// time-keeping and lets the user step minutes/hours with single-cycle pulses.
//
// Ports:
//   maqs_clock       in   system clock, rising edge
//   maqs_reset       in   asynchronous, active-low reset
//   maqmh_addminuto  in   minute carry (level, edge-detected here)
//   maqmh_set        in   1 = set mode
//   maqmh_inc_min    in   1-cycle pulse: step minutes (set mode only)
//   maqmh_inc_hour   in   1-cycle pulse: step hours (set mode only)
//   maqmh_min_lsd    out  minutes units, BCD 0-9
//   maqmh_min_msd    out  minutes tens, 0-5
//   maqmh_hour_lsd   out  hours units, BCD 0-9
//   maqmh_hour_msd   out  hours tens, 0-2 (0-1 in 12 h mode)
//   maqmh_pm         out  PM flag (12 h mode only, else 0)
//   maqmh_addday     out  1-cycle end-of-day pulse
module maq_mh #(
  parameter int H12_MODE = 0
) (
  input  logic       maqs_clock,
  input  logic       maqs_reset,
  input  logic       maqmh_addminuto,
  input  logic       maqmh_set,
  input  logic       maqmh_inc_min,
  input  logic       maqmh_inc_hour,
  output logic [3:0] maqmh_min_lsd,
  output logic [2:0] maqmh_min_msd,
  output logic [3:0] maqmh_hour_lsd,
  output logic [1:0] maqmh_hour_msd,
  output logic       maqmh_pm,
  output logic       maqmh_addday
);

  // Hours value after reset: 00 in 24 h mode, 12 (AM) in 12 h mode.
  localparam logic [1:0] HOUR_MSD_RST = (H12_MODE != 0) ? 2'd1 : 2'd0;
  localparam logic [3:0] HOUR_LSD_RST = (H12_MODE != 0) ? 4'd2 : 4'd0;

  logic       prev_r;
  logic [3:0] min_lsd_r;
  logic [2:0] min_msd_r;
  logic [3:0] hour_lsd_r;
  logic [1:0] hour_msd_r;
  logic       pm_r;
  logic       addday_r;

  logic       evt_s;
  logic       run_step_s;
  logic       min_step_s;
  logic       min_wrap_s;
  logic       hour_step_s;
  logic       day_roll_s;
  logic [3:0] min_lsd_s;
  logic [2:0] min_msd_s;
  logic [3:0] hour_lsd_s;
  logic [1:0] hour_msd_s;
  logic       pm_s;
  logic       addday_s;

  // Step qualification: carries count only in run mode, pulses only in set mode.
  always_comb begin
    evt_s       = maqmh_addminuto & ~prev_r;
    run_step_s  = evt_s & ~maqmh_set;
    min_step_s  = run_step_s | (maqmh_set & maqmh_inc_min);
    min_wrap_s  = (min_msd_r == 3'd5) && (min_lsd_r == 4'd9);
    // A minute wrap carries into hours only when driven by the run-mode carry.
    hour_step_s = (run_step_s & min_wrap_s) | (maqmh_set & maqmh_inc_hour);
  end

  // Minutes next-value: BCD increment with 59 -> 00 wrap.
  always_comb begin
    min_lsd_s = min_lsd_r;
    min_msd_s = min_msd_r;
    if (min_step_s) begin
      if (min_wrap_s) begin
        min_lsd_s = 4'd0;
        min_msd_s = 3'd0;
      end else if (min_lsd_r == 4'd9) begin
        min_lsd_s = 4'd0;
        min_msd_s = min_msd_r + 3'd1;
      end else begin
        min_lsd_s = min_lsd_r + 4'd1;
      end
    end else begin
      min_lsd_s = min_lsd_r;
      min_msd_s = min_msd_r;
    end
  end

  // Hours next-value, PM toggle and end-of-day detection for both hour formats.
  always_comb begin
    hour_lsd_s = hour_lsd_r;
    hour_msd_s = hour_msd_r;
    pm_s       = pm_r;
    day_roll_s = 1'b0;
    if (hour_step_s) begin
      if (H12_MODE != 0) begin
        if ((hour_msd_r == 2'd1) && (hour_lsd_r == 4'd2)) begin
          hour_msd_s = 2'd0;
          hour_lsd_s = 4'd1;
        end else if ((hour_msd_r == 2'd1) && (hour_lsd_r == 4'd1)) begin
          // 11 -> 12 flips AM/PM; leaving PM is the end of the day.
          hour_msd_s = 2'd1;
          hour_lsd_s = 4'd2;
          pm_s       = ~pm_r;
          day_roll_s = pm_r;
        end else if (hour_lsd_r == 4'd9) begin
          hour_msd_s = hour_msd_r + 2'd1;
          hour_lsd_s = 4'd0;
        end else begin
          hour_lsd_s = hour_lsd_r + 4'd1;
        end
      end else begin
        if ((hour_msd_r == 2'd2) && (hour_lsd_r == 4'd3)) begin
          hour_msd_s = 2'd0;
          hour_lsd_s = 4'd0;
          day_roll_s = 1'b1;
        end else if (hour_lsd_r == 4'd9) begin
          hour_msd_s = hour_msd_r + 2'd1;
          hour_lsd_s = 4'd0;
        end else begin
          hour_lsd_s = hour_lsd_r + 4'd1;
        end
      end
    end else begin
      hour_lsd_s = hour_lsd_r;
      hour_msd_s = hour_msd_r;
    end
    // Only a carry-driven rollover produces the day pulse, never a set-mode step.
    addday_s = run_step_s & min_wrap_s & day_roll_s;
  end

  // State registers; prev_r resets to 1 so a carry already high at release is ignored.
  always_ff @(posedge maqs_clock or negedge maqs_reset) begin
    if (!maqs_reset) begin
      prev_r     <= 1'b1;
      min_lsd_r  <= 4'd0;
      min_msd_r  <= 3'd0;
      hour_lsd_r <= HOUR_LSD_RST;
      hour_msd_r <= HOUR_MSD_RST;
      pm_r       <= 1'b0;
      addday_r   <= 1'b0;
    end else begin
      prev_r     <= maqmh_addminuto;
      min_lsd_r  <= min_lsd_s;
      min_msd_r  <= min_msd_s;
      hour_lsd_r <= hour_lsd_s;
      hour_msd_r <= hour_msd_s;
      pm_r       <= pm_s;
      addday_r   <= addday_s;
    end
  end

  assign maqmh_min_lsd  = min_lsd_r;
  assign maqmh_min_msd  = min_msd_r;
  assign maqmh_hour_lsd = hour_lsd_r;
  assign maqmh_hour_msd = hour_msd_r;
  assign maqmh_pm       = pm_r;
  assign maqmh_addday   = addday_r;

endmodule

// File: tb/tb_maq_mh.sv
// Testbench for maq_mh: one 24 h and one 12 h instance share the same
// stimulus; a reference model keeps time as plain integers (hour 0..23,
// minute 0..59) and derives both display formats from it.
module tb_maq_mh;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic addm = 1'b0;
  logic set_i = 1'b0;
  logic inc_min = 1'b0;
  logic inc_hour = 1'b0;

  logic [3:0] a_min_lsd, b_min_lsd;
  logic [2:0] a_min_msd, b_min_msd;
  logic [3:0] a_hour_lsd, b_hour_lsd;
  logic [1:0] a_hour_msd, b_hour_msd;
  logic       a_pm, b_pm, a_addday, b_addday;

  maq_mh #(.H12_MODE(0)) dut24 (
    .maqs_clock(clk), .maqs_reset(rst_n), .maqmh_addminuto(addm),
    .maqmh_set(set_i), .maqmh_inc_min(inc_min), .maqmh_inc_hour(inc_hour),
    .maqmh_min_lsd(a_min_lsd), .maqmh_min_msd(a_min_msd),
    .maqmh_hour_lsd(a_hour_lsd), .maqmh_hour_msd(a_hour_msd),
    .maqmh_pm(a_pm), .maqmh_addday(a_addday)
  );

  maq_mh #(.H12_MODE(1)) dut12 (
    .maqs_clock(clk), .maqs_reset(rst_n), .maqmh_addminuto(addm),
    .maqmh_set(set_i), .maqmh_inc_min(inc_min), .maqmh_inc_hour(inc_hour),
    .maqmh_min_lsd(b_min_lsd), .maqmh_min_msd(b_min_msd),
    .maqmh_hour_lsd(b_hour_lsd), .maqmh_hour_msd(b_hour_msd),
    .maqmh_pm(b_pm), .maqmh_addday(b_addday)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  int m_min, m_hour;
  bit m_prev, m_addday;

  logic [14:0] got24, got12;
  assign got24 = {a_min_msd, a_min_lsd, a_hour_msd, a_hour_lsd, a_pm, a_addday};
  assign got12 = {b_min_msd, b_min_lsd, b_hour_msd, b_hour_lsd, b_pm, b_addday};

  function automatic logic [14:0] exp24();
    logic [2:0] mm; logic [3:0] ml; logic [1:0] hm; logic [3:0] hl;
    mm = 3'(m_min / 10); ml = 4'(m_min % 10);
    hm = 2'(m_hour / 10); hl = 4'(m_hour % 10);
    return {mm, ml, hm, hl, 1'b0, m_addday};
  endfunction

  function automatic logic [14:0] exp12();
    int hh;
    logic [2:0] mm; logic [3:0] ml; logic [1:0] hm; logic [3:0] hl; logic pm;
    hh = ((m_hour % 12) == 0) ? 12 : (m_hour % 12);
    mm = 3'(m_min / 10); ml = 4'(m_min % 10);
    hm = 2'(hh / 10); hl = 4'(hh % 10);
    pm = (m_hour >= 12);
    return {mm, ml, hm, hl, pm, m_addday};
  endfunction

  task automatic model_reset();
    m_min = 0; m_hour = 0; m_prev = 1'b1; m_addday = 1'b0;
  endtask

  // Advance the model by the rules, using the inputs about to be sampled.
  task automatic model_step();
    bit evt;
    evt = addm && !m_prev;
    m_prev = addm;
    m_addday = 1'b0;
    if (!set_i) begin
      if (evt) begin
        m_min++;
        if (m_min == 60) begin
          m_min = 0;
          m_hour++;
          if (m_hour == 24) begin
            m_hour = 0;
            m_addday = 1'b1;
          end
        end
      end
    end else begin
      if (inc_min) m_min = (m_min + 1) % 60;
      if (inc_hour) m_hour = (m_hour + 1) % 24;
    end
  endtask

  // One clock: inputs already driven (at negedge); sample at next negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Preload a time using set-mode pulses; leaves set mode active.
  task automatic set_time(input int th, input int tm);
    set_i = 1'b1; addm = 1'b0;
    while (m_hour != th) begin inc_hour = 1'b1; tick(); end
    inc_hour = 1'b0;
    while (m_min != tm) begin inc_min = 1'b1; tick(); end
    inc_min = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; addm = 1'b1;
    model_reset();
    @(negedge clk);
    tests_run++;
    if (got24 !== exp24()) begin tests_failed++; $display("FAIL reset24: got %h want %h", got24, exp24()); end
    tests_run++;
    if (got12 !== exp12()) begin tests_failed++; $display("FAIL reset12: got %h want %h", got12, exp12()); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (got24 !== exp24()) begin tests_failed++; $display("FAIL held_after_reset24: got %h want %h", got24, exp24()); end
    end
    addm = 1'b0; tick();
    addm = 1'b1; tick();
    tests_run++;
    if (got24 !== exp24() || m_min != 1) begin tests_failed++; $display("FAIL first_edge24: got %h want %h", got24, exp24()); end
    tests_run++;
    if (got12 !== exp12()) begin tests_failed++; $display("FAIL first_edge12: got %h want %h", got12, exp12()); end
    addm = 1'b0; tick();
  endtask

  task automatic test_hour_carry();
    set_time(12, 59);
    set_i = 1'b0; tick();
    addm = 1'b1; tick();
    tests_run++;
    if (got24 !== exp24() || m_hour != 13) begin tests_failed++; $display("FAIL hour_carry24: got %h want %h", got24, exp24()); end
    tests_run++;
    if (got12 !== exp12()) begin tests_failed++; $display("FAIL hour_carry12: got %h want %h", got12, exp12()); end
    addm = 1'b0; tick();
    set_time(11, 59);
    set_i = 1'b0; tick();
    addm = 1'b1; tick();
    tests_run++;
    if (got12 !== exp12() || m_hour != 12) begin tests_failed++; $display("FAIL noon12: got %h want %h", got12, exp12()); end
    tests_run++;
    if (got24 !== exp24()) begin tests_failed++; $display("FAIL noon24: got %h want %h", got24, exp24()); end
    addm = 1'b0; tick();
  endtask

  task automatic test_day_rollover();
    set_time(23, 59);
    set_i = 1'b0; tick();
    addm = 1'b1; tick();
    tests_run++;
    if (got24 !== exp24() || !m_addday) begin tests_failed++; $display("FAIL rollover24: got %h want %h", got24, exp24()); end
    tests_run++;
    if (got12 !== exp12()) begin tests_failed++; $display("FAIL rollover12: got %h want %h", got12, exp12()); end
    tick();
    tests_run++;
    if (got24 !== exp24()) begin tests_failed++; $display("FAIL addday_width24: got %h want %h", got24, exp24()); end
    tests_run++;
    if (got12 !== exp12()) begin tests_failed++; $display("FAIL addday_width12: got %h want %h", got12, exp12()); end
    addm = 1'b0; tick();
  endtask

  task automatic test_set_mode();
    set_time(10, 59);
    addm = 1'b1; tick();
    tests_run++;
    if (got24 !== exp24() || m_min != 59) begin tests_failed++; $display("FAIL set_ignores_carry: got %h want %h", got24, exp24()); end
    inc_min = 1'b1; tick(); inc_min = 1'b0;
    tests_run++;
    if (got24 !== exp24() || m_hour != 10 || m_min != 0) begin tests_failed++; $display("FAIL set_min_wrap: got %h want %h", got24, exp24()); end
    inc_min = 1'b1; inc_hour = 1'b1; tick(); inc_min = 1'b0; inc_hour = 1'b0;
    tests_run++;
    if (got24 !== exp24() || m_hour != 11 || m_min != 1) begin tests_failed++; $display("FAIL set_both: got %h want %h", got24, exp24()); end
    tests_run++;
    if (got12 !== exp12()) begin tests_failed++; $display("FAIL set_both12: got %h want %h", got12, exp12()); end
    // Leaving set mode with the carry still high must not count a deferred edge.
    set_i = 1'b0; tick();
    tests_run++;
    if (got24 !== exp24()) begin tests_failed++; $display("FAIL set_exit: got %h want %h", got24, exp24()); end
    addm = 1'b0; tick();
  endtask

  task automatic test_held_and_reset();
    int start;
    start = m_min;
    addm = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (got24 !== exp24() || m_min != (start + 1) % 60) begin tests_failed++; $display("FAIL held_one_step: got %h want %h", got24, exp24()); end
    addm = 1'b0; tick();
    addm = 1'b1; model_step(); @(posedge clk);
    #2 rst_n = 1'b0; model_reset();
    #1;
    tests_run++;
    if (got24 !== exp24()) begin tests_failed++; $display("FAIL async_reset24: got %h want %h", got24, exp24()); end
    tests_run++;
    if (got12 !== exp12()) begin tests_failed++; $display("FAIL async_reset12: got %h want %h", got12, exp12()); end
    @(negedge clk);
    rst_n = 1'b1; addm = 1'b0;
    tick();
  endtask

  task automatic test_random();
    set_time(23, 40);
    set_i = 1'b0;
    for (int i = 0; i < 400; i++) begin
      addm     = ($urandom_range(0, 99) < 50);
      set_i    = ($urandom_range(0, 99) < 10);
      inc_min  = ($urandom_range(0, 99) < 40);
      inc_hour = ($urandom_range(0, 99) < 20);
      tick();
      tests_run++;
      if (got24 !== exp24()) begin tests_failed++; $display("FAIL random24 cycle %0d: got %h want %h", i, got24, exp24()); end
      tests_run++;
      if (got12 !== exp12()) begin tests_failed++; $display("FAIL random12 cycle %0d: got %h want %h", i, got12, exp12()); end
    end
    addm = 1'b0; set_i = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hour_carry();
    test_day_rollover();
    test_set_mode();
    test_held_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
